control_unit: RTL and testbench
===============================

# control_unit

Multicycle control FSM for the MIPS-subset CPU. It sits directly upstream of the datapath: it consumes the opcode/funct fields and ALU flags, and produces every write-enable, mux select and ALU operation code that the datapath uses. It sequences fetch, decode, execute, memory and write-back, and handles overflow and invalid-opcode exceptions.

## Interface
Parameters:
- SP_INIT, 227: value written to $29 during reset sequence
- VEC_OPCODE, 253: memory byte address holding invalid-opcode handler target
- VEC_OVF, 254: memory byte address holding overflow handler target

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction bits [31:26] from IR
- funct  in  6  instruction bits [5:0] from IR
- overflow  in  1  ALU arithmetic overflow, combinational from current ALU op
- zero  in  1  ALU result-is-zero flag
- PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutWrite, EPCWrite, MDRWrite  out  1 each  register/memory write enables
- ALUSrcA  out  2  0=PC, 1=A, 2=MDR
- ALUSrcB  out  2  0=B, 1=const 4, 2=signext(imm), 3=signext(imm)<<2
- ALUControl  out  3  000=pass A, 001=add, 010=sub, 011=and
- RegDst  out  2  0=rt, 1=rd, 2=$29, 3=$31
- DataSrc  out  2  0=ALUOut, 1=MDR, 2=SP_INIT constant
- IorD  out  2  0=PC, 1=ALUOut, 2=exception vector
- PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=zero-extended MDR[7:0]
- ExcpCtrl  out  2  0=VEC_OPCODE, 1=VEC_OVF

## Operation
- Instructions: R-type add (0x20), sub (0x22), and (0x24); addi (0x08); lw (0x23); sw (0x2B); beq (0x04); j (0x02). Any other opcode, or R-type with unlisted funct → invalid-opcode exception.
- States: RESET, FETCH, FETCH_WAIT, DECODE, EXEC_R, EXEC_I, WB_R, WB_I, MEM_ADDR, MEM_READ, MEM_WAIT, MEM_WB, MEM_WRITE, BRANCH, JUMP, EXC_EPC, EXC_READ, EXC_WAIT, EXC_JUMP.
- RESET: RegWrite=1, RegDst=2, DataSrc=2 ($29←SP_INIT) → FETCH.
- FETCH: IorD=0 (memory captures PC); ALU PC+4, PCSource=0, PCWrite=1 → FETCH_WAIT.
- FETCH_WAIT: IRWrite=1 → DECODE.
- DECODE: ABWrite=1; ALUOut←PC+(signext(imm)<<2) → dispatch on opcode/funct.
- EXEC_R/EXEC_I: A op B / A+signext(imm); ALUOutWrite=1. overflow=1 on add/sub/addi → EXC_EPC (cause=OVF), else WB_R/WB_I. and never overflows.
- WB_R: RegDst=1, DataSrc=0, RegWrite=1. WB_I: RegDst=0, RegWrite=1.
- MEM_ADDR: ALUOut←A+signext(imm) → MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: IorD=1 → MEM_WAIT (MDRWrite=1) → MEM_WB (RegDst=0, DataSrc=1, RegWrite=1).
- MEM_WRITE: IorD=1, MemWrite=1.
- BRANCH: A−B; PCSource=1; PCWrite=zero.
- JUMP: PCSource=2, PCWrite=1.
- EXC_EPC: ALU PC−4, EPCWrite=1. EXC_READ: IorD=2. EXC_WAIT: MDRWrite=1. EXC_JUMP: PCSource=3, PCWrite=1.
- All terminal states → FETCH.
- Cause register latched at exception detection; ExcpCtrl driven from it in EXC_READ through EXC_JUMP.

## Timing
- Outputs Moore-decoded from state, except PCWrite in BRANCH (combinational from zero).
- Outputs not listed for a state are 0.
- Reset asserted in any cycle: next state RESET; cause register←0. All enables except RESET's RegWrite are 0 while reset is high.
- Memory read latency: 1 cycle (address cycle, then data-valid cycle).
- Cycle counts from FETCH: R/addi 5, lw 7, sw 5, beq 4, j 4.
- Exception path: 4 cycles after the detecting state.
- Overflow sampled only in EXEC_R/EXEC_I. On overflow, WB is skipped and the destination register is unchanged.

## Structure
- Package control_pkg: state enum; opcode/funct constants; ALUControl codes; all mux-select encodings; exception cause codes.
- Single module, no sub-module; next-state logic and output decode as separate combinational processes.

## Test plan
- Reset 2 cycles, release → one RESET cycle with RegWrite=1, RegDst=2, DataSrc=2; FETCH follows.
- add with overflow=0 → states FETCH, FETCH_WAIT, DECODE, EXEC_R, WB_R; RegWrite=1 only in WB_R, RegDst=1.
- lw → 7 cycles; IorD=1 in MEM_READ; MDRWrite in MEM_WAIT; RegWrite=1, DataSrc=1 in MEM_WB.
- beq with zero=1 → PCWrite=1, PCSource=1 in BRANCH. With zero=0 → PCWrite=0.
- addi with overflow=1 in EXEC_I → no WB_I; EPCWrite in EXC_EPC; ExcpCtrl=1 through EXC_JUMP; PCWrite with PCSource=3; then FETCH.
- opcode 0x3F → DECODE goes to EXC_EPC with ExcpCtrl=0. Reset asserted during EXC_WAIT → RESET next cycle, no PCWrite.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: FSM states,
// instruction fields, ALU codes, datapath mux selects and exception causes.
package control_pkg;

  typedef enum logic [4:0] {
    ST_RESET      = 5'd0,
    ST_FETCH      = 5'd1,
    ST_FETCH_WAIT = 5'd2,
    ST_DECODE     = 5'd3,
    ST_EXEC_R     = 5'd4,
    ST_EXEC_I     = 5'd5,
    ST_WB_R       = 5'd6,
    ST_WB_I       = 5'd7,
    ST_MEM_ADDR   = 5'd8,
    ST_MEM_READ   = 5'd9,
    ST_MEM_WAIT   = 5'd10,
    ST_MEM_WB     = 5'd11,
    ST_MEM_WRITE  = 5'd12,
    ST_BRANCH     = 5'd13,
    ST_JUMP       = 5'd14,
    ST_EXC_EPC    = 5'd15,
    ST_EXC_READ   = 5'd16,
    ST_EXC_WAIT   = 5'd17,
    ST_EXC_JUMP   = 5'd18
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] ALU_AND    = 3'b011;

  localparam logic [1:0] SRCA_PC  = 2'd0;
  localparam logic [1:0] SRCA_A   = 2'd1;
  localparam logic [1:0] SRCA_MDR = 2'd2;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_SP = 2'd2;
  localparam logic [1:0] RD_RA = 2'd3;

  localparam logic [1:0] DS_ALUOUT  = 2'd0;
  localparam logic [1:0] DS_MDR     = 2'd1;
  localparam logic [1:0] DS_SP_INIT = 2'd2;

  localparam logic [1:0] AD_PC     = 2'd0;
  localparam logic [1:0] AD_ALUOUT = 2'd1;
  localparam logic [1:0] AD_VECTOR = 2'd2;

  localparam logic [1:0] PCS_ALU     = 2'd0;
  localparam logic [1:0] PCS_ALUOUT  = 2'd1;
  localparam logic [1:0] PCS_JUMP    = 2'd2;
  localparam logic [1:0] PCS_MDR_LO8 = 2'd3;

  localparam logic [1:0] CAUSE_OPCODE = 2'd0;
  localparam logic [1:0] CAUSE_OVF    = 2'd1;

  function automatic logic funct_valid(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_PASS_A;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back
// and the overflow / invalid-opcode exception path for the datapath.
module control_unit
  import control_pkg::*;
#(
  parameter int unsigned SP_INIT    = 227,
  parameter int unsigned VEC_OPCODE = 253,
  parameter int unsigned VEC_OVF    = 254
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       zero,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ABWrite,
  output logic       ALUOutWrite,
  output logic       EPCWrite,
  output logic       MDRWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] RegDst,
  output logic [1:0] DataSrc,
  output logic [1:0] IorD,
  output logic [1:0] PCSource,
  output logic [1:0] ExcpCtrl
);

  // Handler targets arrive through the zero-extended MDR[7:0] jump, so the
  // vectors and initial SP must live in the 8-bit byte address space.
  if (SP_INIT > 255 || VEC_OPCODE > 255 || VEC_OVF > 255 || VEC_OPCODE == VEC_OVF) begin : g_param_check
    $error("control_unit: SP_INIT/VEC_* must be < 256 and vectors distinct");
  end

  state_e     state_q, state_d;
  state_e     dec_state;
  logic [1:0] cause_q, cause_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RESET;
      cause_q <= CAUSE_OPCODE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_RESET:      state_d = ST_FETCH;
      ST_FETCH:      state_d = ST_FETCH_WAIT;
      ST_FETCH_WAIT: state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct_valid(funct)) begin
              state_d = ST_EXEC_R;
            end else begin
              state_d = ST_EXC_EPC;
              cause_d = CAUSE_OPCODE;
            end
          end
          OP_ADDI:      state_d = ST_EXEC_I;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          default: begin
            state_d = ST_EXC_EPC;
            cause_d = CAUSE_OPCODE;
          end
        endcase
      end
      ST_EXEC_R: begin
        if (overflow && funct != FN_AND) begin
          state_d = ST_EXC_EPC;
          cause_d = CAUSE_OVF;
        end else begin
          state_d = ST_WB_R;
        end
      end
      ST_EXEC_I: begin
        if (overflow) begin
          state_d = ST_EXC_EPC;
          cause_d = CAUSE_OVF;
        end else begin
          state_d = ST_WB_I;
        end
      end
      ST_MEM_ADDR:   state_d = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:   state_d = ST_MEM_WAIT;
      ST_MEM_WAIT:   state_d = ST_MEM_WB;
      ST_EXC_EPC:    state_d = ST_EXC_READ;
      ST_EXC_READ:   state_d = ST_EXC_WAIT;
      ST_EXC_WAIT:   state_d = ST_EXC_JUMP;
      ST_WB_R, ST_WB_I, ST_MEM_WB, ST_MEM_WRITE,
      ST_BRANCH, ST_JUMP, ST_EXC_JUMP:
                     state_d = ST_FETCH;
      default:       state_d = ST_RESET;
    endcase
  end

  // While reset is high, decode as RESET so no stale enable from the
  // interrupted state reaches the datapath.
  assign dec_state = reset ? ST_RESET : state_q;

  always_comb begin
    PCWrite     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ABWrite     = 1'b0;
    ALUOutWrite = 1'b0;
    EPCWrite    = 1'b0;
    MDRWrite    = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_B;
    ALUControl  = ALU_PASS_A;
    RegDst      = RD_RT;
    DataSrc     = DS_ALUOUT;
    IorD        = AD_PC;
    PCSource    = PCS_ALU;
    ExcpCtrl    = CAUSE_OPCODE;
    case (dec_state)
      ST_RESET: begin
        RegWrite = 1'b1;
        RegDst   = RD_SP;
        DataSrc  = DS_SP_INIT;
      end
      ST_FETCH: begin
        IorD       = AD_PC;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        PCSource   = PCS_ALU;
        PCWrite    = 1'b1;
      end
      ST_FETCH_WAIT: IRWrite = 1'b1;
      ST_DECODE: begin
        ABWrite     = 1'b1;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_IMM_SH2;
        ALUControl  = ALU_ADD;
        ALUOutWrite = 1'b1;
      end
      ST_EXEC_R: begin
        ALUSrcA     = SRCA_A;
        ALUSrcB     = SRCB_B;
        ALUControl  = funct_alu(funct);
        ALUOutWrite = 1'b1;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        ALUSrcA     = SRCA_A;
        ALUSrcB     = SRCB_IMM;
        ALUControl  = ALU_ADD;
        ALUOutWrite = 1'b1;
      end
      ST_WB_R: begin
        RegDst   = RD_RD;
        DataSrc  = DS_ALUOUT;
        RegWrite = 1'b1;
      end
      ST_WB_I: begin
        RegDst   = RD_RT;
        DataSrc  = DS_ALUOUT;
        RegWrite = 1'b1;
      end
      ST_MEM_READ: IorD = AD_ALUOUT;
      ST_MEM_WAIT: MDRWrite = 1'b1;
      ST_MEM_WB: begin
        RegDst   = RD_RT;
        DataSrc  = DS_MDR;
        RegWrite = 1'b1;
      end
      ST_MEM_WRITE: begin
        IorD     = AD_ALUOUT;
        MemWrite = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_B;
        ALUControl = ALU_SUB;
        PCSource   = PCS_ALUOUT;
        PCWrite    = zero;
      end
      ST_JUMP: begin
        PCSource = PCS_JUMP;
        PCWrite  = 1'b1;
      end
      ST_EXC_EPC: begin
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_SUB;
        EPCWrite   = 1'b1;
      end
      ST_EXC_READ: begin
        IorD     = AD_VECTOR;
        ExcpCtrl = cause_q;
      end
      ST_EXC_WAIT: begin
        MDRWrite = 1'b1;
        ExcpCtrl = cause_q;
      end
      ST_EXC_JUMP: begin
        PCSource = PCS_MDR_LO8;
        PCWrite  = 1'b1;
        ExcpCtrl = cause_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected control
// sequences built from the instruction-level behaviour, compared every cycle.
module tb_control_unit;

  typedef struct packed {
    logic       pcw, memw, irw, regw, abw, aluow, epcw, mdrw;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic [1:0] regdst;
    logic [1:0] datasrc;
    logic [1:0] iord;
    logic [1:0] pcsrc;
    logic [1:0] excp;
  } ctl_t;

  logic       clk;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       overflow, zero;
  logic       PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutWrite, EPCWrite, MDRWrite;
  logic [1:0] ALUSrcA, ALUSrcB, RegDst, DataSrc, IorD, PCSource, ExcpCtrl;
  logic [2:0] ALUControl;
  ctl_t       got;

  int   tests = 0;
  int   fails = 0;
  ctl_t exp_q[$];
  logic ovf_sel, z_sel;

  control_unit #(.SP_INIT(227), .VEC_OPCODE(253), .VEC_OVF(254)) dut (
    .clock(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .overflow(overflow), .zero(zero),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ABWrite(ABWrite), .ALUOutWrite(ALUOutWrite), .EPCWrite(EPCWrite), .MDRWrite(MDRWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegDst(RegDst),
    .DataSrc(DataSrc), .IorD(IorD), .PCSource(PCSource), .ExcpCtrl(ExcpCtrl)
  );

  assign got = {PCWrite, MemWrite, IRWrite, RegWrite, ABWrite, ALUOutWrite, EPCWrite, MDRWrite,
                ALUSrcA, ALUSrcB, ALUControl, RegDst, DataSrc, IorD, PCSource, ExcpCtrl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  function automatic ctl_t reset_ctl();
    ctl_t c = '0;
    c.regw = 1'b1; c.regdst = 2'd2; c.datasrc = 2'd2;
    return c;
  endfunction

  function automatic logic is_valid_fn(input logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h22 || fn == 6'h24;
  endfunction

  task automatic push_exc(input logic [1:0] cause);
    ctl_t c;
    c = '0; c.srcb = 2'd1; c.aluc = 3'b010; c.epcw = 1'b1;     exp_q.push_back(c);
    c = '0; c.iord = 2'd2; c.excp = cause;                     exp_q.push_back(c);
    c = '0; c.mdrw = 1'b1; c.excp = cause;                     exp_q.push_back(c);
    c = '0; c.pcsrc = 2'd3; c.pcw = 1'b1; c.excp = cause;      exp_q.push_back(c);
  endtask

  // Expected per-cycle controls of one instruction, starting at fetch.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic z);
    ctl_t c;
    exp_q.delete();
    ovf_sel = ovf;
    z_sel   = z;
    opcode  = op;
    funct   = fn;
    c = '0; c.pcw = 1'b1; c.srcb = 2'd1; c.aluc = 3'b001;                    exp_q.push_back(c);
    c = '0; c.irw = 1'b1;                                                    exp_q.push_back(c);
    c = '0; c.abw = 1'b1; c.aluow = 1'b1; c.srcb = 2'd3; c.aluc = 3'b001;    exp_q.push_back(c);
    case (op)
      6'h00: begin
        if (is_valid_fn(fn)) begin
          c = '0; c.aluow = 1'b1; c.srca = 2'd1;
          c.aluc = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
          exp_q.push_back(c);
          if (ovf && fn != 6'h24) push_exc(2'd1);
          else begin
            c = '0; c.regw = 1'b1; c.regdst = 2'd1; exp_q.push_back(c);
          end
        end else push_exc(2'd0);
      end
      6'h08: begin
        c = '0; c.aluow = 1'b1; c.srca = 2'd1; c.srcb = 2'd2; c.aluc = 3'b001; exp_q.push_back(c);
        if (ovf) push_exc(2'd1);
        else begin
          c = '0; c.regw = 1'b1; exp_q.push_back(c);
        end
      end
      6'h23, 6'h2B: begin
        c = '0; c.aluow = 1'b1; c.srca = 2'd1; c.srcb = 2'd2; c.aluc = 3'b001; exp_q.push_back(c);
        if (op == 6'h23) begin
          c = '0; c.iord = 2'd1;                      exp_q.push_back(c);
          c = '0; c.mdrw = 1'b1;                      exp_q.push_back(c);
          c = '0; c.regw = 1'b1; c.datasrc = 2'd1;    exp_q.push_back(c);
        end else begin
          c = '0; c.iord = 2'd1; c.memw = 1'b1;       exp_q.push_back(c);
        end
      end
      6'h04: begin
        c = '0; c.srca = 2'd1; c.aluc = 3'b010; c.pcsrc = 2'd1; c.pcw = z; exp_q.push_back(c);
      end
      6'h02: begin
        c = '0; c.pcsrc = 2'd2; c.pcw = 1'b1; exp_q.push_back(c);
      end
      default: push_exc(2'd0);
    endcase
  endtask

  // Plays exp_q cycle by cycle; abort_at >= 0 raises reset in that cycle.
  task automatic run_seq(input string name, input int abort_at);
    ctl_t c;
    for (int k = 0; k < exp_q.size(); k++) begin
      overflow = (k == 3) ? ovf_sel : 1'($urandom);
      zero     = (k == 3) ? z_sel   : 1'($urandom);
      if (k == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({got.pcw, got.memw, got.irw, got.abw, got.aluow, got.epcw, got.mdrw} !== 7'b0) begin
          fails++;
          $display("FAIL %s_reset_enables cycle %0d: got %h required enables 0", name, k, got);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        c = reset_ctl();
        @(negedge clk);
        tests++;
        if (got !== c) begin
          fails++;
          $display("FAIL %s_reset_state: got %h required %h", name, got, c);
        end
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      tests++;
      if (got !== exp_q[k]) begin
        fails++;
        $display("FAIL %s cycle %0d: got %h required %h", name, k, got, exp_q[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    ctl_t c;
    reset = 1'b1; opcode = '0; funct = '0; overflow = 1'b0; zero = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      tests++;
      if ({got.pcw, got.memw, got.irw, got.abw, got.aluow, got.epcw, got.mdrw} !== 7'b0) begin
        fails++;
        $display("FAIL reset_hold: got %h required enables 0", got);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    c = reset_ctl();
    @(negedge clk);
    tests++;
    if (got !== c) begin
      fails++;
      $display("FAIL reset_cycle: got %h required %h", got, c);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    build(6'h00, 6'h20, 1'b0, 1'b0); run_seq("add", -1);
    build(6'h00, 6'h22, 1'b1, 1'b0); run_seq("sub_ovf", -1);
    build(6'h00, 6'h24, 1'b1, 1'b0); run_seq("and_ovf_ignored", -1);
    build(6'h23, 6'h00, 1'b0, 1'b0); run_seq("lw", -1);
    build(6'h2B, 6'h11, 1'b0, 1'b0); run_seq("sw", -1);
    build(6'h04, 6'h00, 1'b0, 1'b1); run_seq("beq_taken", -1);
    build(6'h04, 6'h00, 1'b0, 1'b0); run_seq("beq_not_taken", -1);
    build(6'h02, 6'h00, 1'b0, 1'b0); run_seq("j", -1);
    build(6'h08, 6'h00, 1'b1, 1'b0); run_seq("addi_ovf", -1);
    build(6'h3F, 6'h00, 1'b0, 1'b0); run_seq("bad_opcode", -1);
    build(6'h00, 6'h21, 1'b0, 1'b0); run_seq("bad_funct", -1);
  endtask

  task automatic test_reset_in_exception();
    build(6'h3F, 6'h00, 1'b0, 1'b0);
    run_seq("exc_abort", 5);
    build(6'h08, 6'h00, 1'b0, 1'b0);
    run_seq("addi_after_abort", -1);
  endtask

  task automatic test_back_to_back();
    build(6'h08, 6'h00, 1'b1, 1'b0); run_seq("b2b_addi_ovf", -1);
    build(6'h3F, 6'h00, 1'b0, 1'b0); run_seq("b2b_bad_after_ovf", -1);
    build(6'h2B, 6'h00, 1'b0, 1'b0); run_seq("b2b_sw", -1);
    build(6'h02, 6'h00, 1'b0, 1'b0); run_seq("b2b_j", -1);
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    for (int n = 0; n < 300; n++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 9))
        0, 8, 9: begin op = 6'h00; fn = (fn[0]) ? 6'h20 : (fn[1] ? 6'h22 : 6'h24); end
        1: begin op = 6'h00; if (is_valid_fn(fn)) fn = fn ^ 6'h01; end
        2: op = 6'h08;
        3: op = 6'h23;
        4: op = 6'h2B;
        5: op = 6'h04;
        6: op = 6'h02;
        default: op = 6'($urandom);
      endcase
      build(op, fn, $urandom_range(0, 2) == 0, 1'($urandom));
      run_seq("random", -1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_in_exception();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
